// File: rtl/conv_window_gen_pkg.sv
// Shared window geometry for the 3x3 sliding-window generator.
// Tap numbering is row-major: top-left is tap 0, bottom-right is tap 8.
package conv_window_gen_pkg;

   localparam int WIN_K    = 3;
   localparam int WIN_TAPS = WIN_K * WIN_K;

   function automatic int tap(input int i, input int j);
      return WIN_K * i + j;
   endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle of the window generator.
// in_valid qualifies in_sof and in_data; there is no ready in either direction,
// so every pixel with in_valid=1 is taken and every win_valid strobe must be consumed.
interface conv_window_gen_if #(
   parameter int WIDTH = 8,
   parameter int IMG_W = 26,
   parameter int IMG_H = 26
);
   import conv_window_gen_pkg::*;

   localparam int COL_BITS = $clog2(IMG_W);
   localparam int ROW_BITS = $clog2(IMG_H);

   logic                      in_valid;
   logic                      in_sof;
   logic [WIDTH-1:0]          in_data;
   logic                      win_valid;
   logic [WIN_TAPS*WIDTH-1:0] win_data;
   logic [ROW_BITS-1:0]       win_row;
   logic [COL_BITS-1:0]       win_col;
   logic                      frame_done;

   modport master (
      output in_valid, in_sof, in_data,
      input  win_valid, win_data, win_row, win_col, frame_done
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output win_valid, win_data, win_row, win_col, frame_done
   );

endinterface

// File: rtl/conv_window_gen_line_delay_en.sv
// Enable-gated row delay line: so presents the word shifted in DEPTH enables ago.
// No reset so the array can map onto shift-register primitives.
module line_delay_en #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 26
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] si,
   output logic [WIDTH-1:0] so
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         r_sr[0] <= si;
         for (int k = 1; k < DEPTH; k++) begin
            r_sr[k] <= r_sr[k-1];
         end
      end
   end

   assign so = r_sr[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two row delay lines feed a 3x3 register array,
// and a registered output stage emits one window per in-frame accepted pixel.
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IMG_W = 26,
   parameter int IMG_H = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   conv_window_gen_if.slave bus
);

   localparam int COL_BITS = $clog2(IMG_W);
   localparam int ROW_BITS = $clog2(IMG_H);
   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_W - 1);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_H - 1);

   logic [COL_BITS-1:0]       r_col;
   logic [ROW_BITS-1:0]       r_row;
   logic [WIDTH-1:0]          r_win [WIN_K][WIN_K];

   logic                      r_win_valid;
   logic                      r_frame_done;
   logic [WIN_TAPS*WIDTH-1:0] r_win_data;
   logic [ROW_BITS-1:0]       r_win_row;
   logic [COL_BITS-1:0]       r_win_col;

   logic [COL_BITS-1:0]       w_col;
   logic [ROW_BITS-1:0]       w_row;
   logic [COL_BITS-1:0]       w_col_nxt;
   logic [ROW_BITS-1:0]       w_row_nxt;
   logic                      w_emit;
   logic                      w_last;
   logic [WIDTH-1:0]          w_lb0_so;
   logic [WIDTH-1:0]          w_lb1_so;
   logic [WIDTH-1:0]          w_win [WIN_K][WIN_K];
   logic [WIN_TAPS*WIDTH-1:0] w_win_flat;

   line_delay_en #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
      .clk (clk),
      .en  (bus.in_valid),
      .si  (bus.in_data),
      .so  (w_lb0_so)
   );

   line_delay_en #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
      .clk (clk),
      .en  (bus.in_valid),
      .si  (w_lb0_so),
      .so  (w_lb1_so)
   );

   // A start-of-frame pixel is (0,0) no matter where the counters stand.
   always_comb begin
      w_col     = (bus.in_valid && bus.in_sof) ? '0 : r_col;
      w_row     = (bus.in_valid && bus.in_sof) ? '0 : r_row;
      w_col_nxt = (w_col == LAST_COL) ? '0 : w_col + COL_BITS'(1);
      w_row_nxt = w_row;
      if (w_col == LAST_COL) begin
         w_row_nxt = (w_row == LAST_ROW) ? '0 : w_row + ROW_BITS'(1);
      end
      w_emit = bus.in_valid && (w_row >= ROW_BITS'(2)) && (w_col >= COL_BITS'(2));
      w_last = (w_row == LAST_ROW) && (w_col == LAST_COL);
   end

   // Window after this pixel: shift left, new right column from the delay lines.
   always_comb begin
      for (int i = 0; i < WIN_K; i++) begin
         for (int j = 0; j < WIN_K - 1; j++) begin
            w_win[i][j] = r_win[i][j+1];
         end
      end
      w_win[0][WIN_K-1] = w_lb1_so;
      w_win[1][WIN_K-1] = w_lb0_so;
      w_win[2][WIN_K-1] = bus.in_data;
      w_win_flat = '0;
      for (int i = 0; i < WIN_K; i++) begin
         for (int j = 0; j < WIN_K; j++) begin
            w_win_flat[tap(i, j)*WIDTH +: WIDTH] = w_win[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         r_win <= w_win;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_win_data   <= '0;
         r_win_row    <= '0;
         r_win_col    <= '0;
      end else begin
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.in_valid) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            if (w_emit) begin
               r_win_valid  <= 1'b1;
               r_frame_done <= w_last;
               r_win_data   <= w_win_flat;
               r_win_row    <= w_row - ROW_BITS'(2);
               r_win_col    <= w_col - COL_BITS'(2);
            end
         end
      end
   end

   assign bus.win_valid  = r_win_valid;
   assign bus.frame_done = r_frame_done;
   assign bus.win_data   = r_win_data;
   assign bus.win_row    = r_win_row;
   assign bus.win_col    = r_win_col;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 5x4 8-bit instance and a 3x3 16-bit instance,
// raster stimulus with expected windows queued at issue and checked by monitors.
module tb_conv_window_gen;
   import conv_window_gen_pkg::*;

   typedef struct {
      logic [143:0] data;
      logic [7:0]   row;
      logic [7:0]   col;
      logic         done;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;
   logic prev_acc_a;
   logic prev_acc_b;
   int   done_cnt_a;

   conv_window_gen_if #(.WIDTH(8),  .IMG_W(5), .IMG_H(4)) ifa ();
   conv_window_gen_if #(.WIDTH(16), .IMG_W(3), .IMG_H(3)) ifb ();

   conv_window_gen #(.WIDTH(8), .IMG_W(5), .IMG_H(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   conv_window_gen #(.WIDTH(16), .IMG_W(3), .IMG_H(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      prev_acc_a <= ifa.in_valid && rst_n;
      prev_acc_b <= ifb.in_valid && rst_n;
   end

   // Monitors: every window strobe pops one expectation.
   always @(negedge clk) begin
      if (ifa.win_valid) begin
         if (ifa.frame_done) done_cnt_a++;
         chk("a_valid_after_accept", 144'(prev_acc_a), 144'(1));
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_window: got row %0d col %0d, expected no window",
                     ifa.win_row, ifa.win_col);
         end else begin
            ea = qa.pop_front();
            chk("a_win_data", 144'(ifa.win_data), ea.data);
            chk("a_win_row", 144'(ifa.win_row), 144'(ea.row));
            chk("a_win_col", 144'(ifa.win_col), 144'(ea.col));
            chk("a_frame_done", 144'(ifa.frame_done), 144'(ea.done));
         end
      end else if (ifa.frame_done) begin
         checks++;
         errors++;
         $display("FAIL a_done_without_window: got frame_done=1, expected 0");
      end
   end

   always @(negedge clk) begin
      if (ifb.win_valid) begin
         chk("b_valid_after_accept", 144'(prev_acc_b), 144'(1));
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_window: got row %0d col %0d, expected no window",
                     ifb.win_row, ifb.win_col);
         end else begin
            eb = qb.pop_front();
            chk("b_win_data", 144'(ifb.win_data), eb.data);
            chk("b_win_row", 144'(ifb.win_row), 144'(eb.row));
            chk("b_win_col", 144'(ifb.win_col), 144'(eb.col));
            chk("b_frame_done", 144'(ifb.frame_done), 144'(eb.done));
         end
      end else if (ifb.frame_done) begin
         checks++;
         errors++;
         $display("FAIL b_done_without_window: got frame_done=1, expected 0");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix_a(input logic [7:0] d, input logic sof);
      ifa.in_valid = 1'b1;
      ifa.in_sof   = sof;
      ifa.in_data  = d;
      step();
      ifa.in_valid = 1'b0;
      ifa.in_sof   = 1'b0;
   endtask

   task automatic pix_b(input logic [15:0] d, input logic sof);
      ifb.in_valid = 1'b1;
      ifb.in_sof   = sof;
      ifb.in_data  = d;
      step();
      ifb.in_valid = 1'b0;
      ifb.in_sof   = 1'b0;
   endtask

   // Sends the first npix pixels of a 5x4 frame, value base + row*16 + col.
   task automatic frame_a(input logic [7:0] base, input bit gaps, input bit sof, input int npix);
      exp_t e;
      int   r;
      int   c;
      for (int p = 0; p < npix; p++) begin
         r = p / 5;
         c = p % 5;
         if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) step();
         end
         if (r >= 2 && c >= 2) begin
            e.data = '0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  e.data[(3*i+j)*8 +: 8] = base + 8'((r - 2 + i) * 16 + (c - 2 + j));
               end
            end
            e.row  = 8'(r - 2);
            e.col  = 8'(c - 2);
            e.done = (p == 19);
            qa.push_back(e);
         end
         pix_a(base + 8'(r * 16 + c), sof && (p == 0));
      end
   endtask

   task automatic drain(input string name);
      repeat (3) step();
      chk(name, 144'(qa.size() + qb.size()), 144'(0));
   endtask

   initial begin
      exp_t e;
      rst_n        = 1'b0;
      ifa.in_valid = 1'b0;
      ifa.in_sof   = 1'b0;
      ifa.in_data  = '0;
      ifb.in_valid = 1'b0;
      ifb.in_sof   = 1'b0;
      ifb.in_data  = '0;
      done_cnt_a   = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid", 144'(ifa.win_valid), 144'(0));
      chk("rst_a_done", 144'(ifa.frame_done), 144'(0));
      chk("rst_a_data", 144'(ifa.win_data), 144'(0));
      chk("rst_a_rowcol", 144'({ifa.win_row, ifa.win_col}), 144'(0));
      chk("rst_b_all", 144'({ifb.win_valid, ifb.frame_done, ifb.win_row, ifb.win_col}), 144'(0));
      chk("rst_b_data", 144'(ifb.win_data), 144'(0));
      step();
      rst_n = 1'b1;
      step();

      // 1: continuous frame
      frame_a(8'h00, 1'b0, 1'b1, 20);
      drain("t1_all_windows_seen");

      // 2: same frame with random gaps
      frame_a(8'h00, 1'b1, 1'b1, 20);
      drain("t2_all_windows_seen");

      // 3: restart on pixel 8, then on pixel 14 after two windows were already due
      frame_a(8'h40, 1'b0, 1'b1, 8);
      frame_a(8'h00, 1'b0, 1'b1, 20);
      drain("t3a_all_windows_seen");
      frame_a(8'h40, 1'b0, 1'b1, 14);
      frame_a(8'h08, 1'b0, 1'b1, 20);
      drain("t3b_all_windows_seen");

      // 4: reset at pixel (2,3), next frame starts without sof
      frame_a(8'h00, 1'b0, 1'b1, 13);
      rst_n        = 1'b0;
      ifa.in_valid = 1'b1;
      ifa.in_data  = 8'h23;
      step();
      rst_n        = 1'b1;
      ifa.in_valid = 1'b0;
      @(negedge clk);
      chk("t4_valid_after_rst", 144'(ifa.win_valid), 144'(0));
      chk("t4_data_after_rst", 144'(ifa.win_data), 144'(0));
      chk("t4_rowcol_after_rst", 144'({ifa.win_row, ifa.win_col}), 144'(0));
      chk("t4_done_after_rst", 144'(ifa.frame_done), 144'(0));
      step();
      frame_a(8'h20, 1'b0, 1'b0, 20);
      drain("t4_all_windows_seen");

      // 5: back-to-back frames, second offset by 0x80
      done_cnt_a = 0;
      frame_a(8'h00, 1'b0, 1'b1, 20);
      frame_a(8'h80, 1'b0, 1'b0, 20);
      drain("t5_all_windows_seen");
      chk("t5_frame_done_count", 144'(done_cnt_a), 144'(2));

      // 6: 3x3 frame of all-ones 16-bit pixels -> one window
      for (int p = 0; p < 9; p++) begin
         if (p == 8) begin
            e.data = '1;
            e.row  = 8'd0;
            e.col  = 8'd0;
            e.done = 1'b1;
            qb.push_back(e);
         end
         pix_b(16'hFFFF, p == 0);
      end
      drain("t6_all_windows_seen");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
